vlc_input_cond: RTL
===================

VLC_INPUT_COND -- requirements
Module: vlc_input_cond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, SHALL set the consecutive-cycle count a synchronized input must differ from its accepted value before it is accepted; legal range 2..65535.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-high reset (1 = reset asserted).
REQ-004 raw_left  input  1  SHALL carry the asynchronous left turn-stalk switch level.
REQ-005 raw_right  input  1  SHALL carry the asynchronous right turn-stalk switch level.
REQ-006 raw_emg  input  1  SHALL carry the asynchronous hazard-switch level.
REQ-007 Turn_Left  output  1  SHALL be the registered, clean left-turn command to the lamp sequencer.
REQ-008 Turn_Right  output  1  SHALL be the registered, clean right-turn command.
REQ-009 Emergency  output  1  SHALL be the registered, clean hazard command.
REQ-010 conflict  output  1  SHALL be high while both accepted turn inputs are 1 and accepted hazard is 0.
REQ-011 cmd_valid  output  1  SHALL pulse high for one cycle when {Emergency,Turn_Left,Turn_Right} changes.

Function
REQ-012 Each raw input SHALL pass through its own 2-flop synchronizer (sync1, sync2) before any other logic.
REQ-013 Each channel SHALL hold an accepted level "stable" and a debounce counter of width ceil(log2(DEBOUNCE_CYCLES+1)).
REQ-014 Counter rule per edge: sync2 == stable -> counter := 0; sync2 != stable and counter < DEBOUNCE_CYCLES-1 -> counter += 1; sync2 != stable and counter == DEBOUNCE_CYCLES-1 -> stable := sync2, counter := 0.
REQ-015 A sync2 excursion shorter than DEBOUNCE_CYCLES consecutive cycles SHALL leave stable unchanged and reset the counter on return.
REQ-016 Counter SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap-around).
REQ-017 Arbitration (combinational on stable values, result registered): emg=1 -> Emergency=1, Turn_Left=0, Turn_Right=0, conflict=0.
REQ-018 emg=0, left=1, right=1 -> Emergency=0, Turn_Left=0, Turn_Right=0, conflict=1.
REQ-019 Otherwise -> Emergency=0, Turn_Left=left, Turn_Right=right, conflict=0.
REQ-020 Latency: raw input changed before sampling edge 1 and held constant -> outputs reflect it after edge DEBOUNCE_CYCLES+3, not earlier.
REQ-021 cmd_valid SHALL be 1 in exactly the cycle in which the registered command triple first shows a new value, 0 otherwise; a change of conflict alone SHALL NOT raise cmd_valid.
REQ-022 Channels SHALL debounce independently; simultaneous acceptance on several channels in one edge SHALL produce one arbitrated update and one cmd_valid pulse.

Reset
REQ-023 While rst_n=1, all synchronizer flops, stable levels, counters, Turn_Left, Turn_Right, Emergency, conflict and cmd_valid SHALL be 0 immediately, independent of clk.
REQ-024 Reset asserted mid-debounce SHALL discard partial counts; after release, a held input requires the full DEBOUNCE_CYCLES+3 edges again.
REQ-025 The first cycle after reset release SHALL NOT produce cmd_valid unless the command triple actually changes from all-zero.

Verification (DEBOUNCE_CYCLES=4 unless stated)
REQ-026 Reset, raw_left 0->1 held -> Turn_Left=1 after edge 7 (0 after edge 6), cmd_valid=1 for that one cycle only.
REQ-027 raw_right high for 3 cycles then low -> Turn_Right stays 0, cmd_valid never asserted, counter returns to 0.
REQ-028 raw_left=1 accepted, then raw_emg 0->1 held -> after 7 edges Emergency=1, Turn_Left=0, one cmd_valid pulse; raw_emg released -> Turn_Left=1 returns 7 edges later.
REQ-029 raw_left and raw_right rise together -> after edge 7 conflict=1, all commands 0, no cmd_valid.
REQ-030 raw_left held, rst_n pulsed high at edge 4 -> outputs 0 asynchronously; after release Turn_Left=1 only after 7 further edges.
REQ-031 DEBOUNCE_CYCLES=65535, raw_emg held -> Emergency=1 after edge 65538 exactly, counter never wraps.

Source files
------------

// File: rtl/vlc_input_cond.sv
// +--------------------------------------------------------------------------+
// | Module      : vlc_input_cond                                             |
// | Description : Synchronizes, debounces and arbitrates turn/hazard switches |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module vlc_input_cond #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_left,
    input  logic raw_right,
    input  logic raw_emg,
    output logic Turn_Left,
    output logic Turn_Right,
    output logic Emergency,
    output logic conflict,
    output logic cmd_valid
);

    localparam int              c_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    // Channel order: 0 = left, 1 = right, 2 = hazard
    logic [2:0] w_raw;
    logic [2:0] w_stable;
    logic [2:0] w_cmd;
    logic       w_conflict;
    logic [2:0] r_cmd;
    logic       r_conflict;
    logic       r_valid;

    assign w_raw = {raw_emg, raw_right, raw_left};

    for (genvar i = 0; i < 3; i++) begin : g_chan
        logic               r_sync1;
        logic               r_sync2;
        logic               r_stable;
        logic [c_CNT_W-1:0] r_cnt;

        always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) begin
                r_sync1  <= 1'b0;
                r_sync2  <= 1'b0;
                r_stable <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_sync1 <= w_raw[i];
                r_sync2 <= r_sync1;
                // Any return to the accepted level discards the partial count
                if (r_sync2 == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end
        end

        assign w_stable[i] = r_stable;
    end

    always_comb begin
        w_cmd      = 3'b000;
        w_conflict = 1'b0;
        if (w_stable[2]) begin
            w_cmd = 3'b100;
        end else if (w_stable[0] && w_stable[1]) begin
            w_conflict = 1'b1;
        end else begin
            w_cmd = {1'b0, w_stable[0], w_stable[1]};
        end
    end

    // cmd_valid rises together with the new registered command, never on conflict alone
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_cmd      <= 3'b000;
            r_conflict <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_cmd      <= w_cmd;
            r_conflict <= w_conflict;
            r_valid    <= (w_cmd != r_cmd);
        end
    end

    assign Emergency  = r_cmd[2];
    assign Turn_Left  = r_cmd[1];
    assign Turn_Right = r_cmd[0];
    assign conflict   = r_conflict;
    assign cmd_valid  = r_valid;

endmodule

`default_nettype wire
